result_monitor: RTL and testbench

RESULT_MONITOR -- requirements
Module: result_monitor

---
 rtl/result_monitor_pkg.sv | 14 +
 rtl/sample_fifo.sv | 64 ++++++
 rtl/result_monitor.sv | 145 ++++++++++++++
 tb/tb_result_monitor.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_monitor_pkg.sv
// Shared types and constants for the result monitor: FSM states, mode encodings.
package result_monitor_pkg;

    typedef enum logic {
        SETTLE = 1'b0,
        RUN    = 1'b1
    } state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_EVENT    = 1'b1;

    localparam int unsigned SETTLE_W = 4;

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through sample FIFO; when empty, the read port holds the last popped entry.
module sample_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   CLOCK_50,
    input  logic                   RESET,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] last_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? last_q : mem[rd_ptr];

    // Pointers, occupancy and last-popped register.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                last_q <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge CLOCK_50) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/result_monitor.sv
// Result monitor: captures {data, flags} periodically or on events into a FWFT FIFO.
module result_monitor
    import result_monitor_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned FLAG_W  = 4,
    parameter int unsigned PERIOD  = 6,
    parameter int unsigned STARTUP = 1,
    parameter int unsigned DEPTH   = 8
) (
    input  logic                   CLOCK_50,
    input  logic                   RESET,
    input  logic                   enable,
    input  logic                   mode,
    input  logic [DATA_W-1:0]      data_in,
    input  logic [FLAG_W-1:0]      flags_in,
    input  logic                   event_in,
    input  logic                   out_ready,
    input  logic                   clear_ovf,
    output logic [DATA_W-1:0]      result_out,
    output logic [FLAG_W-1:0]      flags_out,
    output logic                   out_valid,
    output logic [$clog2(DEPTH):0] count_out,
    output logic                   overflow
);

    localparam int unsigned ENTRY_W = DATA_W + FLAG_W;
    localparam int unsigned PCNT_W  = $clog2(PERIOD);

    state_t              state_q;
    state_t              state_d;
    logic [SETTLE_W-1:0] scnt_q;
    logic [SETTLE_W-1:0] scnt_d;
    logic [PCNT_W-1:0]   pcnt_q;
    logic [PCNT_W-1:0]   pcnt_d;
    logic                mode_q;
    logic                mode_chg;
    logic                settle_done;
    logic                capture;
    logic                pop;
    logic                drop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [ENTRY_W-1:0]  fifo_rdata;

    assign mode_chg    = (mode != mode_q);
    assign settle_done = (STARTUP == 0) || (enable && (scnt_q == SETTLE_W'(STARTUP - 1)));

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= SETTLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SETTLE:  if (settle_done) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = SETTLE;
        endcase
    end

    // Counter updates and capture decision.
    always_comb begin
        capture = 1'b0;
        scnt_d  = scnt_q;
        pcnt_d  = pcnt_q;
        case (state_q)
            SETTLE: begin
                pcnt_d = '0;
                if (enable) scnt_d = scnt_q + SETTLE_W'(1);
            end
            RUN: begin
                if (mode == MODE_EVENT) begin
                    pcnt_d  = '0;
                    capture = enable && event_in;
                end else if (mode_chg) begin
                    pcnt_d = '0;
                end else if (enable) begin
                    if (pcnt_q == PCNT_W'(PERIOD - 1)) begin
                        capture = 1'b1;
                        pcnt_d  = '0;
                    end else begin
                        pcnt_d = pcnt_q + PCNT_W'(1);
                    end
                end
            end
            default: begin
                scnt_d = '0;
                pcnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            scnt_q <= '0;
            pcnt_q <= '0;
            mode_q <= MODE_PERIODIC;
        end else begin
            scnt_q <= scnt_d;
            pcnt_q <= pcnt_d;
            mode_q <= mode;
        end
    end

    assign pop  = !fifo_empty && out_ready;
    assign drop = capture && fifo_full && !pop;

    // Sticky overflow; a drop outranks a simultaneous clear.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

    sample_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .push     (capture),
        .pop      (pop),
        .wdata    ({data_in, flags_in}),
        .rdata    (fifo_rdata),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (count_out)
    );

    assign result_out = fifo_rdata[ENTRY_W-1 -: DATA_W];
    assign flags_out  = fifo_rdata[FLAG_W-1:0];
    assign out_valid  = !fifo_empty;

endmodule

// File: tb/tb_result_monitor.sv
// Self-checking bench for result_monitor: directed scenarios plus randomized traffic vs. a queue model.
module tb_result_monitor;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned FLAG_W  = 4;
    localparam int unsigned PERIOD  = 6;
    localparam int unsigned STARTUP = 1;
    localparam int unsigned DEPTH   = 8;

    typedef logic [DATA_W+FLAG_W-1:0] entry_t;

    logic                   CLOCK_50;
    logic                   RESET;
    logic                   enable;
    logic                   mode;
    logic [DATA_W-1:0]      data_in;
    logic [FLAG_W-1:0]      flags_in;
    logic                   event_in;
    logic                   out_ready;
    logic                   clear_ovf;
    logic [DATA_W-1:0]      result_out;
    logic [FLAG_W-1:0]      flags_out;
    logic                   out_valid;
    logic [$clog2(DEPTH):0] count_out;
    logic                   overflow;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    // Behavioural model state
    entry_t mq[$];
    entry_t m_last;
    bit     m_ovf;
    bit     m_run;
    int     m_settle;
    int     m_enabled_cnt;
    bit     m_prev_mode;
    entry_t exp_e;

    result_monitor #(
        .DATA_W (DATA_W), .FLAG_W (FLAG_W), .PERIOD (PERIOD),
        .STARTUP(STARTUP), .DEPTH (DEPTH)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET     (RESET),
        .enable    (enable),
        .mode      (mode),
        .data_in   (data_in),
        .flags_in  (flags_in),
        .event_in  (event_in),
        .out_ready (out_ready),
        .clear_ovf (clear_ovf),
        .result_out(result_out),
        .flags_out (flags_out),
        .out_valid (out_valid),
        .count_out (count_out),
        .overflow  (overflow)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUT samples at that edge.
    task automatic model_step();
        bit cap;
        bit chg;
        cap = 1'b0;
        if (RESET) begin
            mq.delete();
            m_last        = '0;
            m_ovf         = 1'b0;
            m_run         = 1'b0;
            m_settle      = 0;
            m_enabled_cnt = 0;
            m_prev_mode   = 1'b0;
            return;
        end
        chg         = (mode != m_prev_mode);
        m_prev_mode = mode;
        if (!m_run) begin
            if (STARTUP == 0) begin
                m_run = 1'b1;
            end else if (enable) begin
                m_settle++;
                if (m_settle == int'(STARTUP)) m_run = 1'b1;
            end
        end else if (mode) begin
            m_enabled_cnt = 0;
            cap = enable && event_in;
        end else if (chg) begin
            m_enabled_cnt = 0;
        end else if (enable) begin
            m_enabled_cnt++;
            if (m_enabled_cnt % int'(PERIOD) == 0) begin
                cap = 1'b1;
                m_enabled_cnt = 0;
            end
        end
        if (mq.size() > 0 && out_ready) m_last = mq.pop_front();
        if (cap && mq.size() >= int'(DEPTH)) begin
            m_ovf = 1'b1;
        end else begin
            if (cap) mq.push_back({data_in, flags_in});
            if (clear_ovf) m_ovf = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        model_step();
        #1;
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge CLOCK_50) begin
        if (chk_en) begin
            exp_e = (mq.size() > 0) ? mq[0] : m_last;
            check("count_out", 64'(count_out), 64'(mq.size()));
            check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
            check("result_out", 64'(result_out), 64'(exp_e[DATA_W+FLAG_W-1 -: DATA_W]));
            check("flags_out", 64'(flags_out), 64'(exp_e[FLAG_W-1:0]));
            check("overflow", 64'(overflow), 64'(m_ovf));
        end
    end

    task automatic idle_inputs();
        enable = 1'b1; mode = 1'b0; event_in = 1'b0; out_ready = 1'b1;
        clear_ovf = 1'b0; data_in = '0; flags_in = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RESET = 1'b1;
        repeat (2) tick();
        chk_en = 1'b1;
        check("rst_count", 64'(count_out), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result_out), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        RESET = 1'b0;
    endtask

    // Periodic captures with data_in equal to the cycle index after reset release.
    task automatic periodic_run();
        for (int c = 1; c <= 19; c++) begin
            data_in  = DATA_W'(c);
            flags_in = FLAG_W'(c);
            tick();
            if (c == 6) check("per_c6_valid", 64'(out_valid), 64'd0);
            if (c == 7 || c == 13 || c == 19) begin
                check("per_cap_valid", 64'(out_valid), 64'd1);
                check("per_cap_result", 64'(result_out), 64'(c));
            end
            if (c == 8) begin
                check("per_hold_valid", 64'(out_valid), 64'd0);
                check("per_hold_result", 64'(result_out), 64'd7);
            end
        end
    endtask

    initial begin
        int ready_bias;
        RESET = 1'b1;
        idle_inputs();

        // Periodic capture timing
        do_reset();
        periodic_run();

        // Three event captures, consumer stalled
        do_reset();
        mode = 1'b1; out_ready = 1'b0;
        tick();
        event_in = 1'b1;
        data_in = 32'hA; tick();
        data_in = 32'hB; tick();
        data_in = 32'hC; tick();
        event_in = 1'b0;
        tick();
        check("ev3_count", 64'(count_out), 64'd3);
        check("ev3_head", 64'(result_out), 64'hA);

        // Overflow on a held event
        do_reset();
        mode = 1'b1; out_ready = 1'b0;
        tick();
        event_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data_in = DATA_W'(32'h100 + i);
            tick();
        end
        event_in = 1'b0;
        check("ovf_count", 64'(count_out), 64'd8);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_head", 64'(result_out), 64'h100);

        // Drop beats clear, then clear alone
        event_in = 1'b1; clear_ovf = 1'b1; data_in = 32'h1FF;
        tick();
        check("drop_vs_clear", 64'(overflow), 64'd1);
        event_in = 1'b0;
        tick();
        check("clear_ovf", 64'(overflow), 64'd0);
        clear_ovf = 1'b0;

        // Full FIFO with simultaneous pop and push
        out_ready = 1'b1; event_in = 1'b1; data_in = 32'h200;
        tick();
        event_in = 1'b0;
        check("fullpp_count", 64'(count_out), 64'd8);
        check("fullpp_ovf", 64'(overflow), 64'd0);
        check("fullpp_head", 64'(result_out), 64'h101);
        repeat (7) tick();
        check("drain_tail", 64'(result_out), 64'h200);
        check("drain_count", 64'(count_out), 64'd1);
        repeat (3) tick();
        check("empty_hold", 64'(result_out), 64'h200);
        check("empty_count", 64'(count_out), 64'd0);

        // Mid-operation reset with five entries queued
        do_reset();
        mode = 1'b1; out_ready = 1'b0;
        tick();
        event_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in = DATA_W'(32'h300 + i);
            tick();
        end
        event_in = 1'b0;
        check("pre_rst_count", 64'(count_out), 64'd5);
        RESET = 1'b1;
        tick();
        check("mid_rst_count", 64'(count_out), 64'd0);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        RESET = 1'b0;
        idle_inputs();
        periodic_run();

        // Enable low for four cycles at counter value 3
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            data_in = DATA_W'(c);
            enable  = !(c >= 5 && c <= 8);
            tick();
            if (c == 7 || c == 10) check("en_gap_valid", 64'(out_valid), 64'd0);
            if (c == 11) begin
                check("en_delay_valid", 64'(out_valid), 64'd1);
                check("en_delay_result", 64'(result_out), 64'd11);
            end
        end

        // Randomized traffic
        do_reset();
        ready_bias = 2;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) ready_bias = int'($urandom_range(0, 4));
            RESET     = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 24) == 0) mode = ~mode;
            enable    = ($urandom_range(0, 7) != 0);
            event_in  = $urandom_range(0, 1) == 1;
            out_ready = int'($urandom_range(0, 3)) < ready_bias;
            clear_ovf = ($urandom_range(0, 15) == 0);
            data_in   = DATA_W'($urandom);
            flags_in  = FLAG_W'($urandom_range(0, 15));
            tick();
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
